reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 145 ++++++++++++++
 tb/tb_reg_file.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file -- architectural register file with rename tags for an
// out-of-order core that uses a reorder buffer (ROB).
//
// Each architectural register holds a 32-bit committed value and a TAGW-bit
// producer tag. A tag with MSB=1 names the ROB entry that will write the
// register. A tag of 0 means the stored value is final. x0 always reads 0
// and never takes a write or a rename.
//
// Handshake: there is no valid/ready pairing here. All updates occur on the
// rising clock edge and only when rdy is high. When rdy is low, all state
// holds. The read ports are always combinational.
//
// Ports
//   clk                    in   system clock, rising edge active
//   rst                    in   asynchronous active-high reset (clears all)
//   rdy                    in   global ready; low freezes all state
//   clr                    in   ROB flush: clear every tag, drop the issue
//   issue_to_reg_enable    in   rename request
//   issue_to_reg_rd        in   register being renamed
//   issue_to_reg_rob_pos   in   wrapped ROB tag of the renaming instruction
//   rob_to_reg_enable      in   commit write strobe
//   rob_to_reg_rd          in   committed destination register
//   rob_to_reg_val         in   committed value
//   commit_rob_pos         in   wrapped ROB tag of the committing entry
//   dc_to_reg_rs1_pos/rs2  in   source register indices from the decoder
//   reg_to_dc_rs1_val/rs2  out  operand values
//   reg_to_dc_rs1_rob_pos  out  producer tag for rs1 (0 = value is final)
//   reg_to_dc_rs2_rob_pos  out  producer tag for rs2 (0 = value is final)
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int REG_NUM  = 32,
    parameter int ROB_SIZE = 16,
    localparam int TAGW    = $clog2(ROB_SIZE) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            clr,
    input  logic            issue_to_reg_enable,
    input  logic [4:0]      issue_to_reg_rd,
    input  logic [TAGW-1:0] issue_to_reg_rob_pos,
    input  logic            rob_to_reg_enable,
    input  logic [4:0]      rob_to_reg_rd,
    input  logic [31:0]     rob_to_reg_val,
    input  logic [TAGW-1:0] commit_rob_pos,
    input  logic [4:0]      dc_to_reg_rs1_pos,
    input  logic [4:0]      dc_to_reg_rs2_pos,
    output logic [31:0]     reg_to_dc_rs1_val,
    output logic [31:0]     reg_to_dc_rs2_val,
    output logic [TAGW-1:0] reg_to_dc_rs1_rob_pos,
    output logic [TAGW-1:0] reg_to_dc_rs2_rob_pos
);

    logic [31:0]     value_q [REG_NUM];
    logic [31:0]     value_d [REG_NUM];
    logic [TAGW-1:0] tag_q   [REG_NUM];
    logic [TAGW-1:0] tag_d   [REG_NUM];

    // ------------------------------------------------------------------
    // Next-state logic. Commit is applied first. A same-cycle issue to the
    // same register then overwrites the tag, because the issuing
    // instruction is younger than the committing one. A flush wipes all
    // tags but keeps the commit value write.
    // ------------------------------------------------------------------
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;
        if (rdy) begin
            if (rob_to_reg_enable && rob_to_reg_rd != 5'd0) begin
                value_d[rob_to_reg_rd] = rob_to_reg_val;
                // Clear the tag only if this commit is still the latest
                // producer. A younger rename keeps its tag.
                if (tag_q[rob_to_reg_rd] == commit_rob_pos) begin
                    tag_d[rob_to_reg_rd] = '0;
                end
            end
            if (clr) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    tag_d[i] = '0;
                end
            end else if (issue_to_reg_enable && issue_to_reg_rd != 5'd0) begin
                tag_d[issue_to_reg_rd] = issue_to_reg_rob_pos;
            end
        end
        // x0 is hard-wired zero.
        value_d[0] = '0;
        tag_d[0]   = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= value_d[i];
                tag_q[i]   <= tag_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports. A commit that retires the current producer of a source
    // is forwarded in the same cycle, so the decoder never waits for it.
    // The bypass is gated by rst so that outputs read 0 while reset is
    // asserted, even if a zero-tag commit is presented.
    // ------------------------------------------------------------------
    logic rs1_bypass;
    logic rs2_bypass;

    assign rs1_bypass = !rst && rob_to_reg_enable
                        && rob_to_reg_rd == dc_to_reg_rs1_pos
                        && tag_q[dc_to_reg_rs1_pos] == commit_rob_pos;
    assign rs2_bypass = !rst && rob_to_reg_enable
                        && rob_to_reg_rd == dc_to_reg_rs2_pos
                        && tag_q[dc_to_reg_rs2_pos] == commit_rob_pos;

    always_comb begin
        reg_to_dc_rs1_val     = value_q[dc_to_reg_rs1_pos];
        reg_to_dc_rs1_rob_pos = tag_q[dc_to_reg_rs1_pos];
        if (dc_to_reg_rs1_pos == 5'd0) begin
            reg_to_dc_rs1_val     = '0;
            reg_to_dc_rs1_rob_pos = '0;
        end else if (rs1_bypass) begin
            reg_to_dc_rs1_val     = rob_to_reg_val;
            reg_to_dc_rs1_rob_pos = '0;
        end
    end

    always_comb begin
        reg_to_dc_rs2_val     = value_q[dc_to_reg_rs2_pos];
        reg_to_dc_rs2_rob_pos = tag_q[dc_to_reg_rs2_pos];
        if (dc_to_reg_rs2_pos == 5'd0) begin
            reg_to_dc_rs2_val     = '0;
            reg_to_dc_rs2_rob_pos = '0;
        end else if (rs2_bypass) begin
            reg_to_dc_rs2_val     = rob_to_reg_val;
            reg_to_dc_rs2_rob_pos = '0;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  localparam int TAGW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            rdy;
  logic            clr;
  logic            issue_to_reg_enable;
  logic [4:0]      issue_to_reg_rd;
  logic [TAGW-1:0] issue_to_reg_rob_pos;
  logic            rob_to_reg_enable;
  logic [4:0]      rob_to_reg_rd;
  logic [31:0]     rob_to_reg_val;
  logic [TAGW-1:0] commit_rob_pos;
  logic [4:0]      dc_to_reg_rs1_pos;
  logic [4:0]      dc_to_reg_rs2_pos;
  logic [31:0]     reg_to_dc_rs1_val;
  logic [31:0]     reg_to_dc_rs2_val;
  logic [TAGW-1:0] reg_to_dc_rs1_rob_pos;
  logic [TAGW-1:0] reg_to_dc_rs2_rob_pos;

  reg_file dut (
    .clk                   (clk),
    .rst                   (rst),
    .rdy                   (rdy),
    .clr                   (clr),
    .issue_to_reg_enable   (issue_to_reg_enable),
    .issue_to_reg_rd       (issue_to_reg_rd),
    .issue_to_reg_rob_pos  (issue_to_reg_rob_pos),
    .rob_to_reg_enable     (rob_to_reg_enable),
    .rob_to_reg_rd         (rob_to_reg_rd),
    .rob_to_reg_val        (rob_to_reg_val),
    .commit_rob_pos        (commit_rob_pos),
    .dc_to_reg_rs1_pos     (dc_to_reg_rs1_pos),
    .dc_to_reg_rs2_pos     (dc_to_reg_rs2_pos),
    .reg_to_dc_rs1_val     (reg_to_dc_rs1_val),
    .reg_to_dc_rs2_val     (reg_to_dc_rs2_val),
    .reg_to_dc_rs1_rob_pos (reg_to_dc_rs1_rob_pos),
    .reg_to_dc_rs2_rob_pos (reg_to_dc_rs2_rob_pos)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0]     m_val [32];
  logic [TAGW-1:0] m_tag [32];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0;
      m_tag[i] = '0;
    end
  endtask

  function automatic logic [31:0] ref_val(input logic [4:0] rs);
    if (rs == 0) return '0;
    if (rob_to_reg_enable && rob_to_reg_rd == rs && m_tag[rs] == commit_rob_pos) return rob_to_reg_val;
    return m_val[rs];
  endfunction

  function automatic logic [TAGW-1:0] ref_pos(input logic [4:0] rs);
    if (rs == 0) return '0;
    if (rob_to_reg_enable && rob_to_reg_rd == rs && m_tag[rs] == commit_rob_pos) return '0;
    return m_tag[rs];
  endfunction

  // Applies one clock edge's worth of architectural effect to the model.
  task automatic model_edge();
    logic [TAGW-1:0] old_tag;
    if (rst || !rdy) return;
    if (rob_to_reg_enable && rob_to_reg_rd != 0) begin
      old_tag = m_tag[rob_to_reg_rd];
      m_val[rob_to_reg_rd] = rob_to_reg_val;
      if (old_tag == commit_rob_pos) m_tag[rob_to_reg_rd] = '0;
    end
    if (clr) begin
      for (int i = 0; i < 32; i++) m_tag[i] = '0;
    end else if (issue_to_reg_enable && issue_to_reg_rd != 0) begin
      m_tag[issue_to_reg_rd] = issue_to_reg_rob_pos;
    end
  endtask

  task automatic check_outputs(input string where);
    check_val({where, " rs1_val"}, reg_to_dc_rs1_val, ref_val(dc_to_reg_rs1_pos));
    check_val({where, " rs1_pos"}, {27'd0, reg_to_dc_rs1_rob_pos}, {27'd0, ref_pos(dc_to_reg_rs1_pos)});
    check_val({where, " rs2_val"}, reg_to_dc_rs2_val, ref_val(dc_to_reg_rs2_pos));
    check_val({where, " rs2_pos"}, {27'd0, reg_to_dc_rs2_rob_pos}, {27'd0, ref_pos(dc_to_reg_rs2_pos)});
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rdy = 1'b1; clr = 1'b0;
    issue_to_reg_enable = 1'b0; issue_to_reg_rd = '0; issue_to_reg_rob_pos = '0;
    rob_to_reg_enable = 1'b0; rob_to_reg_rd = '0; rob_to_reg_val = '0; commit_rob_pos = '0;
    dc_to_reg_rs1_pos = '0; dc_to_reg_rs2_pos = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [TAGW-1:0] pos);
    issue_to_reg_enable = 1'b1; issue_to_reg_rd = rd; issue_to_reg_rob_pos = pos;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [TAGW-1:0] pos, input logic [31:0] val);
    rob_to_reg_enable = 1'b1; rob_to_reg_rd = rd; commit_rob_pos = pos; rob_to_reg_val = val;
  endtask

  // Inputs are driven at edge+1; outputs checked mid-cycle; model advanced on the edge.
  task automatic step(input string where);
    #3;
    check_outputs(where);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    model_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    dc_to_reg_rs1_pos = 5'd5; dc_to_reg_rs2_pos = 5'd31;
    #2;
    check_val("reset rs1_val", reg_to_dc_rs1_val, 32'd0);
    check_val("reset rs1_pos", {27'd0, reg_to_dc_rs1_rob_pos}, 32'd0);
    check_val("reset rs2_val", reg_to_dc_rs2_val, 32'd0);
    check_val("reset rs2_pos", {27'd0, reg_to_dc_rs2_rob_pos}, 32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;

    // Rename then read
    idle(); issue(5'd5, 5'h13); step("rename");
    idle(); dc_to_reg_rs1_pos = 5'd5; #1;
    check_val("rename rs1_pos", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h13);
    check_val("rename rs1_val", reg_to_dc_rs1_val, 32'd0);
    step("rename read");

    // Commit bypass
    idle(); commit(5'd5, 5'h13, 32'hDEADBEEF); dc_to_reg_rs2_pos = 5'd5; #1;
    check_val("bypass rs2_val", reg_to_dc_rs2_val, 32'hDEADBEEF);
    check_val("bypass rs2_pos", {27'd0, reg_to_dc_rs2_rob_pos}, 32'd0);
    step("bypass");
    idle(); dc_to_reg_rs1_pos = 5'd5; #1;
    check_val("post commit rs1_pos", {27'd0, reg_to_dc_rs1_rob_pos}, 32'd0);
    check_val("post commit rs1_val", reg_to_dc_rs1_val, 32'hDEADBEEF);
    step("post commit");

    // Stale commit keeps the younger tag
    idle(); issue(5'd7, 5'h15); step("stale setup");
    idle(); commit(5'd7, 5'h12, 32'h55); step("stale commit");
    idle(); dc_to_reg_rs1_pos = 5'd7; #1;
    check_val("stale rs1_val", reg_to_dc_rs1_val, 32'h55);
    check_val("stale rs1_pos", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h15);
    step("stale read");

    // Same-cycle issue and commit to one register
    idle(); issue(5'd3, 5'h16); step("same setup");
    idle(); issue(5'd3, 5'h18); commit(5'd3, 5'h16, 32'h77); step("same cycle");
    idle(); dc_to_reg_rs1_pos = 5'd3; #1;
    check_val("same rs1_val", reg_to_dc_rs1_val, 32'h77);
    check_val("same rs1_pos", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h18);
    step("same read");

    // Flush
    idle(); issue(5'd1, 5'h11); step("flush setup1");
    idle(); issue(5'd2, 5'h12); step("flush setup2");
    idle(); issue(5'd31, 5'h1F); step("flush setup3");
    idle(); clr = 1'b1; commit(5'd1, 5'h00, 32'h9); issue(5'd4, 5'h14); step("flush");
    idle(); dc_to_reg_rs1_pos = 5'd1; dc_to_reg_rs2_pos = 5'd31; #1;
    check_val("flush x1 val", reg_to_dc_rs1_val, 32'h9);
    check_val("flush x1 pos", {27'd0, reg_to_dc_rs1_rob_pos}, 32'd0);
    check_val("flush x31 pos", {27'd0, reg_to_dc_rs2_rob_pos}, 32'd0);
    step("flush read1");
    idle(); dc_to_reg_rs1_pos = 5'd2; dc_to_reg_rs2_pos = 5'd4; #1;
    check_val("flush x2 pos", {27'd0, reg_to_dc_rs1_rob_pos}, 32'd0);
    check_val("flush x4 pos", {27'd0, reg_to_dc_rs2_rob_pos}, 32'd0);
    step("flush read2");

    // x0 discards writes and renames
    idle(); issue(5'd0, 5'h1A); commit(5'd0, 5'h1A, 32'h1); step("x0 write");
    idle(); #1;
    check_val("x0 val", reg_to_dc_rs1_val, 32'd0);
    check_val("x0 pos", {27'd0, reg_to_dc_rs1_rob_pos}, 32'd0);
    step("x0 read");

    // rdy low freezes state
    idle(); rdy = 1'b0; issue(5'd4, 5'h14); commit(5'd4, 5'h00, 32'hAA); step("rdy low");
    idle(); dc_to_reg_rs1_pos = 5'd4; #1;
    check_val("rdy x4 pos", {27'd0, reg_to_dc_rs1_rob_pos}, 32'd0);
    check_val("rdy x4 val", reg_to_dc_rs1_val, 32'd0);
    step("rdy read");

    // Asynchronous reset between edges, with traffic held across an edge
    idle(); issue(5'd6, 5'h17); commit(5'd6, 5'h01, 32'h66); step("rst setup");
    idle(); dc_to_reg_rs1_pos = 5'd6; #1;
    check_val("pre rst val", reg_to_dc_rs1_val, 32'h66);
    check_val("pre rst pos", {27'd0, reg_to_dc_rs1_rob_pos}, 32'h17);
    rst = 1'b1; #1;
    check_val("async rst val", reg_to_dc_rs1_val, 32'd0);
    check_val("async rst pos", {27'd0, reg_to_dc_rs1_rob_pos}, 32'd0);
    model_reset();
    issue(5'd6, 5'h17); commit(5'd6, 5'h19, 32'h66);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(); dc_to_reg_rs1_pos = 5'd6; #1;
    check_val("rst drop val", reg_to_dc_rs1_val, 32'd0);
    check_val("rst drop pos", {27'd0, reg_to_dc_rs1_rob_pos}, 32'd0);
    step("after rst");

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd;
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 1)
        issue(5'($urandom_range(0, 7)), {1'b1, 4'($urandom_range(0, 15))});
      if ($urandom_range(0, 1) == 1) begin
        rd = 5'($urandom_range(0, 7));
        if (m_tag[rd] != 0 && $urandom_range(0, 9) < 6)
          commit(rd, m_tag[rd], $urandom);
        else
          commit(rd, {1'b1, 4'($urandom_range(0, 15))}, $urandom);
      end
      dc_to_reg_rs1_pos = ($urandom_range(0, 1) == 1) ? rob_to_reg_rd : 5'($urandom_range(0, 31));
      dc_to_reg_rs2_pos = 5'($urandom_range(0, 7));
      step("random");
    end

    // Final sweep of every register
    for (int r = 0; r < 32; r += 2) begin
      idle();
      dc_to_reg_rs1_pos = 5'(r); dc_to_reg_rs2_pos = 5'(r + 1);
      step("sweep");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
